// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - two-port fetch/load-store arbiter onto a single non-abortable memory channel
module mem_arbiter #(
    parameter int unsigned STARVE_LIMIT = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        rdy,

    input  logic        if_req_i,
    input  logic [31:0] if_addr_i,
    input  logic        if_flush_i,
    output logic        if_done_o,
    output logic [31:0] if_data_o,

    input  logic        mem_req_i,
    input  logic        mem_wr_i,
    input  logic [31:0] mem_addr_i,
    input  logic [1:0]  mem_size_i,
    input  logic [31:0] mem_wdata_i,
    output logic        mem_done_o,
    output logic [31:0] mem_rdata_o,

    output logic        mc_req_o,
    output logic        mc_wr_o,
    output logic [31:0] mc_addr_o,
    output logic [1:0]  mc_size_o,
    output logic [31:0] mc_wdata_o,
    input  logic        mc_done_i,
    input  logic [31:0] mc_rdata_i
);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        IF_BUSY  = 2'd1,
        MEM_BUSY = 2'd2,
        IF_DRAIN = 2'd3
    } state_t;

    localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);
    localparam logic [1:0] SIZE_WORD = 2'd2;

    state_t      state_q;
    state_t      state_d;
    logic [3:0]  starve_q;
    logic [3:0]  starve_d;

    logic        mc_req_d;
    logic        mc_wr_d;
    logic [31:0] mc_addr_d;
    logic [1:0]  mc_size_d;
    logic [31:0] mc_wdata_d;
    logic        if_done_d;
    logic [31:0] if_data_d;
    logic        mem_done_d;
    logic [31:0] mem_rdata_d;

    // A fetch that is being redirected in the same cycle is never worth starting.
    logic if_ok;
    // MEM normally wins; a starved, still-valid fetch takes one slot back.
    logic mem_grant;
    logic if_grant;

    // Grant selection is only meaningful while the channel is idle.
    always_comb begin
        if_ok     = if_req_i & ~if_flush_i;
        mem_grant = (state_q == IDLE) & mem_req_i & ~((starve_q == LIMIT) & if_ok);
        if_grant  = (state_q == IDLE) & ~mem_grant & if_ok;
    end

    // Next-state, next-output and starvation-counter logic.
    always_comb begin
        state_d     = state_q;
        starve_d    = starve_q;
        mc_req_d    = mc_req_o;
        mc_wr_d     = mc_wr_o;
        mc_addr_d   = mc_addr_o;
        mc_size_d   = mc_size_o;
        mc_wdata_d  = mc_wdata_o;
        if_done_d   = 1'b0;
        if_data_d   = if_data_o;
        mem_done_d  = 1'b0;
        mem_rdata_d = mem_rdata_o;

        case (state_q)
            IDLE: begin
                // mc_done_i is meaningless here: nothing is outstanding.
                if (mem_grant) begin
                    state_d    = MEM_BUSY;
                    mc_req_d   = 1'b1;
                    mc_wr_d    = mem_wr_i;
                    mc_addr_d  = mem_addr_i;
                    mc_size_d  = mem_size_i;
                    mc_wdata_d = mem_wdata_i;
                    if (if_req_i) begin
                        if (starve_q < LIMIT) begin
                            starve_d = starve_q + 4'd1;
                        end
                    end else begin
                        starve_d = 4'd0;
                    end
                end else if (if_grant) begin
                    state_d    = IF_BUSY;
                    mc_req_d   = 1'b1;
                    mc_wr_d    = 1'b0;
                    mc_addr_d  = if_addr_i;
                    mc_size_d  = SIZE_WORD;
                    mc_wdata_d = 32'd0;
                    starve_d   = 4'd0;
                end
            end

            IF_BUSY: begin
                if (mc_done_i) begin
                    state_d  = IDLE;
                    mc_req_d = 1'b0;
                    // A flush landing on the completion cycle still kills the word.
                    if (!if_flush_i) begin
                        if_done_d = 1'b1;
                        if_data_d = mc_rdata_i;
                    end
                end else if (if_flush_i) begin
                    // Downstream cannot abort, so keep requesting and drop the reply.
                    state_d = IF_DRAIN;
                end
            end

            IF_DRAIN: begin
                if (mc_done_i) begin
                    state_d  = IDLE;
                    mc_req_d = 1'b0;
                end
            end

            MEM_BUSY: begin
                if (mc_done_i) begin
                    state_d    = IDLE;
                    mc_req_d   = 1'b0;
                    mem_done_d = 1'b1;
                    if (!mc_wr_o) begin
                        mem_rdata_d = mc_rdata_i;
                    end
                end
            end

            default: begin
                state_d  = IDLE;
                mc_req_d = 1'b0;
            end
        endcase
    end

    // State and output registers; reset beats rdy, rdy low freezes everything.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q     <= IDLE;
            starve_q    <= 4'd0;
            mc_req_o    <= 1'b0;
            mc_wr_o     <= 1'b0;
            mc_addr_o   <= 32'd0;
            mc_size_o   <= 2'd0;
            mc_wdata_o  <= 32'd0;
            if_done_o   <= 1'b0;
            if_data_o   <= 32'd0;
            mem_done_o  <= 1'b0;
            mem_rdata_o <= 32'd0;
        end else if (rdy) begin
            state_q     <= state_d;
            starve_q    <= starve_d;
            mc_req_o    <= mc_req_d;
            mc_wr_o     <= mc_wr_d;
            mc_addr_o   <= mc_addr_d;
            mc_size_o   <= mc_size_d;
            mc_wdata_o  <= mc_wdata_d;
            if_done_o   <= if_done_d;
            if_data_o   <= if_data_d;
            mem_done_o  <= mem_done_d;
            mem_rdata_o <= mem_rdata_d;
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// tb/tb_mem_arbiter.sv - directed vector bench for mem_arbiter
module tb_mem_arbiter;

    typedef struct packed {
        logic        rst;
        logic        rdy;
        logic        if_req;
        logic        if_flush;
        logic [31:0] if_addr;
        logic        mem_req;
        logic        mem_wr;
        logic [31:0] mem_addr;
        logic [1:0]  mem_size;
        logic [31:0] mem_wdata;
        logic        mc_done;
        logic [31:0] mc_rdata;
    } in_t;

    typedef struct packed {
        logic        mc_req;
        logic        mc_wr;
        logic [31:0] mc_addr;
        logic [1:0]  mc_size;
        logic [31:0] mc_wdata;
        logic        if_done;
        logic [31:0] if_data;
        logic        mem_done;
        logic [31:0] mem_rdata;
    } out_t;

    typedef struct packed {
        in_t  i;
        out_t o;
    } vec_t;

    localparam int N = 17;

    logic        clk;
    logic        rst;
    logic        rdy;
    logic        if_req_i;
    logic [31:0] if_addr_i;
    logic        if_flush_i;
    logic        if_done_o;
    logic [31:0] if_data_o;
    logic        mem_req_i;
    logic        mem_wr_i;
    logic [31:0] mem_addr_i;
    logic [1:0]  mem_size_i;
    logic [31:0] mem_wdata_i;
    logic        mem_done_o;
    logic [31:0] mem_rdata_o;
    logic        mc_req_o;
    logic        mc_wr_o;
    logic [31:0] mc_addr_o;
    logic [1:0]  mc_size_o;
    logic [31:0] mc_wdata_o;
    logic        mc_done_i;
    logic [31:0] mc_rdata_i;

    int checks;
    int errors;
    vec_t tbl [N];

    mem_arbiter #(.STARVE_LIMIT(4)) dut (
        .clk         (clk),
        .rst         (rst),
        .rdy         (rdy),
        .if_req_i    (if_req_i),
        .if_addr_i   (if_addr_i),
        .if_flush_i  (if_flush_i),
        .if_done_o   (if_done_o),
        .if_data_o   (if_data_o),
        .mem_req_i   (mem_req_i),
        .mem_wr_i    (mem_wr_i),
        .mem_addr_i  (mem_addr_i),
        .mem_size_i  (mem_size_i),
        .mem_wdata_i (mem_wdata_i),
        .mem_done_o  (mem_done_o),
        .mem_rdata_o (mem_rdata_o),
        .mc_req_o    (mc_req_o),
        .mc_wr_o     (mc_wr_o),
        .mc_addr_o   (mc_addr_o),
        .mc_size_o   (mc_size_o),
        .mc_wdata_o  (mc_wdata_o),
        .mc_done_i   (mc_done_i),
        .mc_rdata_i  (mc_rdata_i)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic in_t mi(input logic r, input logic y, input logic iq, input logic fl,
                               input logic [31:0] ia, input logic mq, input logic mw,
                               input logic [31:0] ma, input logic [1:0] ms, input logic [31:0] mwd,
                               input logic d, input logic [31:0] rd);
        in_t v;
        v.rst = r; v.rdy = y; v.if_req = iq; v.if_flush = fl; v.if_addr = ia;
        v.mem_req = mq; v.mem_wr = mw; v.mem_addr = ma; v.mem_size = ms; v.mem_wdata = mwd;
        v.mc_done = d; v.mc_rdata = rd;
        return v;
    endfunction

    function automatic out_t mo(input logic q, input logic w, input logic [31:0] a,
                                input logic [1:0] s, input logic [31:0] wd, input logic ifd,
                                input logic [31:0] idat, input logic md, input logic [31:0] mrd);
        out_t v;
        v.mc_req = q; v.mc_wr = w; v.mc_addr = a; v.mc_size = s; v.mc_wdata = wd;
        v.if_done = ifd; v.if_data = idat; v.mem_done = md; v.mem_rdata = mrd;
        return v;
    endfunction

    task automatic chk(input string nm, input string fld, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s.%s actual %h required %h", nm, fld, act, exp);
        end
    endtask

    task automatic step(input string nm, input in_t v, input out_t e);
        @(negedge clk);
        rst = v.rst; rdy = v.rdy;
        if_req_i = v.if_req; if_flush_i = v.if_flush; if_addr_i = v.if_addr;
        mem_req_i = v.mem_req; mem_wr_i = v.mem_wr; mem_addr_i = v.mem_addr;
        mem_size_i = v.mem_size; mem_wdata_i = v.mem_wdata;
        mc_done_i = v.mc_done; mc_rdata_i = v.mc_rdata;
        @(posedge clk);
        #1;
        chk(nm, "mc_req",    {31'd0, mc_req_o},   {31'd0, e.mc_req});
        chk(nm, "mc_wr",     {31'd0, mc_wr_o},    {31'd0, e.mc_wr});
        chk(nm, "mc_addr",   mc_addr_o,           e.mc_addr);
        chk(nm, "mc_size",   {30'd0, mc_size_o},  {30'd0, e.mc_size});
        chk(nm, "mc_wdata",  mc_wdata_o,          e.mc_wdata);
        chk(nm, "if_done",   {31'd0, if_done_o},  {31'd0, e.if_done});
        chk(nm, "if_data",   if_data_o,           e.if_data);
        chk(nm, "mem_done",  {31'd0, mem_done_o}, {31'd0, e.mem_done});
        chk(nm, "mem_rdata", mem_rdata_o,         e.mem_rdata);
    endtask

    initial begin
        logic [31:0] ma;
        logic [31:0] mrd;
        checks = 0;
        errors = 0;
        rst = 1'b0; rdy = 1'b0; if_req_i = 1'b0; if_flush_i = 1'b0; if_addr_i = 32'd0;
        mem_req_i = 1'b0; mem_wr_i = 1'b0; mem_addr_i = 32'd0; mem_size_i = 2'd0;
        mem_wdata_i = 32'd0; mc_done_i = 1'b0; mc_rdata_i = 32'd0;

        // Reset, plain fetch, store/fetch collision, load, stray done, flushed request.
        tbl[0]  = '{mi(0,1,0,0,0,0,0,0,0,0,0,0),                 mo(0,0,0,0,0,0,0,0,0)};
        tbl[1]  = '{mi(1,1,1,0,'h100,0,0,0,0,0,0,0),             mo(1,0,'h100,2,0,0,0,0,0)};
        tbl[2]  = '{mi(1,1,1,0,'h100,0,0,0,0,0,0,0),             mo(1,0,'h100,2,0,0,0,0,0)};
        tbl[3]  = '{mi(1,1,1,0,'h100,0,0,0,0,0,0,0),             mo(1,0,'h100,2,0,0,0,0,0)};
        tbl[4]  = '{mi(1,1,1,0,'h100,0,0,0,0,0,0,0),             mo(1,0,'h100,2,0,0,0,0,0)};
        tbl[5]  = '{mi(1,1,1,0,'h100,0,0,0,0,0,0,0),             mo(1,0,'h100,2,0,0,0,0,0)};
        tbl[6]  = '{mi(1,1,1,0,'h100,0,0,0,0,0,1,'h13),          mo(0,0,'h100,2,0,1,'h13,0,0)};
        tbl[7]  = '{mi(1,1,0,0,0,0,0,0,0,0,0,0),                 mo(0,0,'h100,2,0,0,'h13,0,0)};
        tbl[8]  = '{mi(1,1,1,0,'h104,1,1,'h30000,0,'hAB,0,0),    mo(1,1,'h30000,0,'hAB,0,'h13,0,0)};
        tbl[9]  = '{mi(1,1,1,0,'h104,1,1,'h30000,0,'hAB,1,'h5555), mo(0,1,'h30000,0,'hAB,0,'h13,1,0)};
        tbl[10] = '{mi(1,1,1,0,'h104,0,0,0,0,0,0,0),             mo(1,0,'h104,2,0,0,'h13,0,0)};
        tbl[11] = '{mi(1,1,1,0,'h104,0,0,0,0,0,1,'hDEADBEEF),    mo(0,0,'h104,2,0,1,'hDEADBEEF,0,0)};
        tbl[12] = '{mi(1,1,0,0,0,0,0,0,0,0,0,0),                 mo(0,0,'h104,2,0,0,'hDEADBEEF,0,0)};
        tbl[13] = '{mi(1,1,0,0,0,1,0,'h40,1,'h55,0,0),           mo(1,0,'h40,1,'h55,0,'hDEADBEEF,0,0)};
        tbl[14] = '{mi(1,1,0,0,0,1,0,'h40,1,'h55,1,'h1234),      mo(0,0,'h40,1,'h55,0,'hDEADBEEF,1,'h1234)};
        tbl[15] = '{mi(1,1,0,0,0,0,0,0,0,0,1,'hFFFF),            mo(0,0,'h40,1,'h55,0,'hDEADBEEF,0,'h1234)};
        tbl[16] = '{mi(1,1,1,1,'h108,0,0,0,0,0,0,0),             mo(0,0,'h40,1,'h55,0,'hDEADBEEF,0,'h1234)};

        for (int r = 0; r < N; r++) begin
            step($sformatf("row%0d", r), tbl[r].i, tbl[r].o);
        end

        // Starvation: four MEM loads while IF waits, then IF must win.
        mrd = 32'h1234;
        for (int k = 0; k < 4; k++) begin
            ma = 32'h1000 + 32'(k * 4);
            step($sformatf("starve_grant%0d", k), mi(1,1,1,0,'h500,1,0,ma,2,0,0,0),
                 mo(1,0,ma,2,0,0,'hDEADBEEF,0,mrd));
            mrd = 32'hA0 + 32'(k);
            step($sformatf("starve_done%0d", k), mi(1,1,1,0,'h500,1,0,ma,2,0,1,mrd),
                 mo(0,0,ma,2,0,0,'hDEADBEEF,1,mrd));
        end
        step("starve_if_wins", mi(1,1,1,0,'h500,1,0,'h2000,2,0,0,0),  mo(1,0,'h500,2,0,0,'hDEADBEEF,0,'hA3));
        step("starve_if_done", mi(1,1,1,0,'h500,1,0,'h2000,2,0,1,'h600D), mo(0,0,'h500,2,0,1,'h600D,0,'hA3));
        step("starve_cleared", mi(1,1,1,0,'h500,1,0,'h2000,2,0,0,0),  mo(1,0,'h2000,2,0,0,'h600D,0,'hA3));
        step("starve_mem_done", mi(1,1,1,0,'h500,1,0,'h2000,2,0,1,'hB0), mo(0,0,'h2000,2,0,0,'h600D,1,'hB0));
        step("starve_if2",     mi(1,1,1,0,'h500,0,0,0,0,0,0,0),       mo(1,0,'h500,2,0,0,'h600D,0,'hB0));
        step("starve_if2_done", mi(1,1,1,0,'h500,0,0,0,0,0,1,'h11),   mo(0,0,'h500,2,0,1,'h11,0,'hB0));

        // Flush while busy, drain, then a clean fetch; flush coincident with done.
        step("fl_grant",  mi(1,1,1,0,'h200,0,0,0,0,0,0,0),      mo(1,0,'h200,2,0,0,'h11,0,'hB0));
        step("fl_pulse",  mi(1,1,1,1,'h200,0,0,0,0,0,0,0),      mo(1,0,'h200,2,0,0,'h11,0,'hB0));
        step("fl_drain1", mi(1,1,0,0,0,0,0,0,0,0,0,0),          mo(1,0,'h200,2,0,0,'h11,0,'hB0));
        step("fl_drain2", mi(1,1,0,0,0,0,0,0,0,0,0,0),          mo(1,0,'h200,2,0,0,'h11,0,'hB0));
        step("fl_discard", mi(1,1,0,0,0,0,0,0,0,0,1,'h99),      mo(0,0,'h200,2,0,0,'h11,0,'hB0));
        step("fl_next",   mi(1,1,1,0,'h300,0,0,0,0,0,0,0),      mo(1,0,'h300,2,0,0,'h11,0,'hB0));
        step("fl_next_done", mi(1,1,1,0,'h300,0,0,0,0,0,1,'h77), mo(0,0,'h300,2,0,1,'h77,0,'hB0));
        step("fl_co_grant", mi(1,1,1,0,'h304,0,0,0,0,0,0,0),    mo(1,0,'h304,2,0,0,'h77,0,'hB0));
        step("fl_co_done", mi(1,1,1,1,'h304,0,0,0,0,0,1,'h88),  mo(0,0,'h304,2,0,0,'h77,0,'hB0));
        step("fl_co_after", mi(1,1,0,0,0,0,0,0,0,0,0,0),        mo(0,0,'h304,2,0,0,'h77,0,'hB0));
        step("fl_mem_grant", mi(1,1,0,0,0,1,0,'h3000,2,0,0,0),  mo(1,0,'h3000,2,0,0,'h77,0,'hB0));
        step("fl_mem_done", mi(1,1,0,1,0,1,0,'h3000,2,0,1,'hC0), mo(0,0,'h3000,2,0,0,'h77,1,'hC0));

        // Reset in the middle of a load, with rdy low to show reset still wins.
        step("rst_grant", mi(1,1,0,0,0,1,0,'h2000,2,'h5,0,0),   mo(1,0,'h2000,2,'h5,0,'h77,0,'hC0));
        step("rst_mid",   mi(0,0,0,0,0,1,0,'h2000,2,'h5,0,0),   mo(0,0,0,0,0,0,0,0,0));
        step("rst_late_done", mi(1,1,0,0,0,0,0,0,0,0,1,'hBAD), mo(0,0,0,0,0,0,0,0,0));

        // rdy low freezes a busy fetch and stretches the done pulse.
        step("rdy_idle_freeze", mi(1,0,1,0,'h600,0,0,0,0,0,0,0), mo(0,0,0,0,0,0,0,0,0));
        step("rdy_grant", mi(1,1,1,0,'h600,0,0,0,0,0,0,0),       mo(1,0,'h600,2,0,0,0,0,0));
        for (int k = 0; k < 3; k++) begin
            step($sformatf("rdy_hold%0d", k), mi(1,0,1,1,'h700,1,1,'h9000,0,'hFF,0,0),
                 mo(1,0,'h600,2,0,0,0,0,0));
        end
        step("rdy_done", mi(1,1,1,0,'h600,0,0,0,0,0,1,'h42),     mo(0,0,'h600,2,0,1,'h42,0,0));
        step("rdy_stretch0", mi(1,0,0,0,0,0,0,0,0,0,1,'h43),     mo(0,0,'h600,2,0,1,'h42,0,0));
        step("rdy_stretch1", mi(1,0,0,0,0,0,0,0,0,0,1,'h43),     mo(0,0,'h600,2,0,1,'h42,0,0));
        step("rdy_release", mi(1,1,0,0,0,0,0,0,0,0,0,0),         mo(0,0,'h600,2,0,0,'h42,0,0));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
